fpu_wb_scheduler: RTL and testbench
===================================

# fpu_wb_scheduler

Write-back scheduler and scoreboard for the floating-point register file. It shares the register file's single write port between NREQ result producers (FPU pipelines of differing latency and the float load path) using round-robin arbitration. It also tracks per-register pending writes so that the issue stage stalls on RAW and WAW hazards. It sits between the FPU execution units and `float_register`, driving that block's `rdi`, `write_data` and `reg_write`.

## Interface
Parameters:
- NREQ, 4, number of write-back requesters
- REG_ADDR_W, 5, float register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, synchronous and active-low
- req_valid  in  NREQ  requester i holds a result for write-back
- req_rd  in  NREQ*REG_ADDR_W  destination register, slice i belongs to requester i
- req_data  in  NREQ*DATA_W  result data, slice i belongs to requester i
- req_ready  out  NREQ  one-hot grant (combinational); transfer when valid & ready
- wb_we  out  1  to `float_register.reg_write`
- wb_rd  out  REG_ADDR_W  to `float_register.rdi`
- wb_data  out  DATA_W  to `float_register.write_data`
- issue_valid  in  1  issue stage presents an FP instruction
- issue_rs1, issue_rs2, issue_rd  in  REG_ADDR_W each  source and destination addresses
- issue_use_rs1, issue_use_rs2, issue_wr_rd  in  1 each  operand and destination qualifiers
- issue_stall  out  1  combinational hazard stall
- busy  out  2**REG_ADDR_W  scoreboard, bit r set means a write to r is pending

## Operation
- Arbitration: round-robin over req_valid. Priority starts at (last granted index + 1) mod NREQ. The pointer updates only on a grant. At most one req_ready is high per cycle, and none when no request is valid.
- Requesters hold valid, rd and data stable until ready. Dropping valid before ready is illegal.
- Write-back register: on a grant, wb_we<=1, wb_rd<=req_rd[g], wb_data<=req_data[g]. With no grant, wb_we<=0 and wb_rd/wb_data hold their values.
- issue_stall = issue_valid & ((issue_use_rs1 & busy[rs1]) | (issue_use_rs2 & busy[rs2]) | (issue_wr_rd & busy[rd])).
- Issue accepted = issue_valid & !issue_stall. Accepting with issue_wr_rd sets busy[issue_rd].
- A grant clears busy[req_rd[g]] on the same edge that loads wb_*.
- Set and clear of the same register on the same edge: set wins, because the newly issued write is pending.
- A grant to a register whose busy bit is already 0 is still written; busy is unchanged.
- No register is hard-wired to zero. Register 0 is tracked like any other.

## Timing
- Reset (rstn=0 at an edge): busy=0, wb_we=0, wb_rd=0, wb_data=0, RR pointer set so that index 0 has highest priority.
- Reset mid-operation discards all pending busy bits and any in-flight grant. Requesters are reset by the same rstn.
- Grant-to-write latency is 1 cycle: grant in cycle t, wb_we=1 in cycle t+1, register file updated at the end of t+1.
- Busy clears at the end of t, so an instruction issued in t+1 is not stalled. Its operand read at the end of t+1 coincides with the write, and `float_register`'s same-cycle write bypass returns the new value.
- Sustained throughput is one write-back per cycle. With all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- issue_stall and req_ready are purely combinational from inputs and registered state. There are no combinational paths from issue_* to req_ready.

## Structure
- Shared package `fpu_pkg`: REG_ADDR_W, DATA_W, NREQ, requester index constants (REQ_FADD=0, REQ_FMUL=1, REQ_FDIV=2, REQ_FLOAD=3).
- One sub-module, `rr_arbiter` (parameter N), containing the request vector, one-hot grant and pointer register. Reuse it for other shared FPU resources.
- Scoreboard set/clear logic and the write-back register stay in the top module.

## Test plan
- Reset: drive rstn=0 for 2 cycles with all requests valid -> wb_we=0, busy=0, req_ready=0 during reset. The first grant after release goes to index 0.
- Round-robin: hold all 4 req_valid with rd=1,2,3,4 -> grants 0,1,2,3,0 on consecutive cycles. wb_rd is 1,2,3,4,1 one cycle later.
- RAW stall: issue rd=5 (accepted, busy[5]=1), then issue rs1=5 -> stalled. Requester 2 is granted rd=5, data 0x3F800000 in cycle t -> no stall in t+1, and the register file read returns 0x3F800000.
- WAW: with busy[7]=1, issue rd=7 with issue_wr_rd=1 -> stalled. The same instruction with issue_wr_rd=0 and unused sources -> accepted.
- Simultaneous set/clear: grant rd=9 and accept issue rd=9 in the same cycle -> busy[9]=1 afterward, wb_we=1 with wb_rd=9.
- Idle hold: no req_valid for 3 cycles after a write of rd=6, data 0x40490FDB -> wb_we=0, and wb_rd/wb_data hold 6/0x40490FDB.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants: register file geometry and write-back requester indices.
package fpu_pkg;

    localparam int NREQ       = 4;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam int REQ_FADD  = 0;
    localparam int REQ_FMUL  = 1;
    localparam int REQ_FDIV  = 2;
    localparam int REQ_FLOAD = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the search starts one past the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic [PW-1:0] w_idx;
    logic [N-1:0]  w_gnt;
    logic          w_found;
    int            w_sum;

    always_comb begin
        w_gnt      = '0;
        w_found    = 1'b0;
        w_ptr_next = r_ptr;
        w_sum      = 0;
        w_idx      = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(r_ptr) + i;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = PW'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_ptr_next   = (w_sum == N - 1) ? '0 : PW'(w_sum + 1);
            end
        end
    end

    // No grant is offered while reset is asserted.
    assign gnt = rstn ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FP register file write-back scheduler: round-robin write-port sharing plus
// a per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
module fpu_wb_scheduler
    import fpu_pkg::*;
#(
    parameter int NREQ       = fpu_pkg::NREQ,
    parameter int REG_ADDR_W = fpu_pkg::REG_ADDR_W,
    parameter int DATA_W     = fpu_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       wb_we,
    output logic [REG_ADDR_W-1:0]      wb_rd,
    output logic [DATA_W-1:0]          wb_data,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_rs1,
    input  logic [REG_ADDR_W-1:0]      issue_rs2,
    input  logic [REG_ADDR_W-1:0]      issue_rd,
    input  logic                       issue_use_rs1,
    input  logic                       issue_use_rs2,
    input  logic                       issue_wr_rd,
    output logic                       issue_stall,
    output logic [2**REG_ADDR_W-1:0]   busy
);

    localparam int NREG = 2**REG_ADDR_W;

    logic [NREQ-1:0]       w_gnt;
    logic                  w_gnt_any;
    logic [REG_ADDR_W-1:0] w_gnt_rd;
    logic [DATA_W-1:0]     w_gnt_data;
    logic                  w_issue_set;
    logic [NREG-1:0]       w_busy_next;

    logic [NREG-1:0]       r_busy;
    logic                  r_wb_we;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (req_valid),
        .gnt  (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_gnt_rd   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                w_gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign issue_stall = issue_valid &
                         ((issue_use_rs1 & r_busy[issue_rs1]) |
                          (issue_use_rs2 & r_busy[issue_rs2]) |
                          (issue_wr_rd   & r_busy[issue_rd]));

    assign w_issue_set = issue_valid & ~issue_stall & issue_wr_rd;

    // Set is applied after clear: a newly issued write to the same register stays pending.
    always_comb begin
        w_busy_next = r_busy;
        if (w_gnt_any) begin
            w_busy_next[w_gnt_rd] = 1'b0;
        end
        if (w_issue_set) begin
            w_busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy    <= '0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_wb_we <= w_gnt_any;
            if (w_gnt_any) begin
                r_wb_rd   <= w_gnt_rd;
                r_wb_data <= w_gnt_data;
            end
        end
    end

    assign busy    = r_busy;
    assign wb_we   = r_wb_we;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Self-checking bench for fpu_wb_scheduler: directed hazard/arbitration cases, then
// randomized requesters and issue traffic against a behavioural scoreboard model.
module tb_fpu_wb_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_we;
    logic [AW-1:0]        wb_rd;
    logic [DW-1:0]        wb_data;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rs1;
    logic [AW-1:0]        issue_rs2;
    logic [AW-1:0]        issue_rd;
    logic                 issue_use_rs1;
    logic                 issue_use_rs2;
    logic                 issue_wr_rd;
    logic                 issue_stall;
    logic [NREG-1:0]      busy;

    fpu_wb_scheduler dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_wr_rd   (issue_wr_rd),
        .issue_stall   (issue_stall),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // requester side
    logic          v   [NREQ];
    logic [AW-1:0] rdv [NREQ];
    logic [DW-1:0] dv  [NREQ];

    // reference model
    logic [NREG-1:0] m_busy;
    int              m_ptr;
    logic            m_we;
    logic [AW-1:0]   m_rd;
    logic [DW-1:0]   m_data;
    int              last_g;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = v[i];
            req_rd[i*AW +: AW]    = rdv[i];
            req_data[i*DW +: DW]  = dv[i];
        end
    endtask

    function automatic int exp_grant();
        int j;
        if (!rstn) return -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic exp_stall();
        return issue_valid && ((issue_use_rs1 && m_busy[issue_rs1]) ||
                               (issue_use_rs2 && m_busy[issue_rs2]) ||
                               (issue_wr_rd   && m_busy[issue_rd]));
    endfunction

    task automatic cycle(input bit do_chk);
        int   g;
        logic st;
        logic [63:0] exp_rdy;
        @(negedge clk);
        g  = exp_grant();
        st = exp_stall();
        exp_rdy = (g >= 0) ? (64'd1 << g) : 64'd0;
        if (do_chk) begin
            chk("req_ready",   {60'd0, req_ready}, exp_rdy);
            chk("issue_stall", {63'd0, issue_stall}, {63'd0, st});
            chk("wb_we",       {63'd0, wb_we}, {63'd0, m_we});
            chk("wb_rd",       {59'd0, wb_rd}, {59'd0, m_rd});
            chk("wb_data",     {32'd0, wb_data}, {32'd0, m_data});
            chk("busy",        {32'd0, busy}, {32'd0, m_busy});
        end
        @(posedge clk);
        if (!rstn) begin
            m_busy = '0;
            m_ptr  = 0;
            m_we   = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            if (g >= 0) begin
                m_we          = 1'b1;
                m_rd          = rdv[g];
                m_data        = dv[g];
                m_busy[rdv[g]] = 1'b0;
                m_ptr         = (g + 1) % NREQ;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid && !st && issue_wr_rd) m_busy[issue_rd] = 1'b1;
        end
        last_g = g;
        #1;
    endtask

    task automatic issue(input logic val, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic u1, input logic u2, input logic wr);
        issue_valid   = val;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_rd      = rd;
        issue_use_rs1 = u1;
        issue_use_rs2 = u2;
        issue_wr_rd   = wr;
    endtask

    int  rr_seq [5] = '{0, 1, 2, 3, 0};
    bit  prev_rst;

    initial begin
        m_busy = '0; m_ptr = 0; m_we = 1'b0; m_rd = '0; m_data = '0; last_g = -1;
        rstn = 1'b0;
        issue(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NREQ; i++) begin
            v[i]   = 1'b1;
            rdv[i] = AW'(i + 1);
            dv[i]  = $urandom;
        end
        drive();

        // reset with all requests valid
        cycle(0);
        cycle(1);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk("rst_we", {63'd0, wb_we}, 64'd0);
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        rstn = 1'b1;

        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", {60'd0, req_ready}, 64'd1 << rr_seq[k]);
            cycle(1);
            chk("rr_wb_rd", {59'd0, wb_rd}, 64'(rr_seq[k] + 1));
        end
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        drive();

        // RAW
        issue(1'b1, '0, '0, 5'd5, 1'b0, 1'b0, 1'b1);
        #1 chk("raw_accept", {63'd0, issue_stall}, 64'd0);
        cycle(1);
        chk("raw_busy5", {63'd0, busy[5]}, 64'd1);
        issue(1'b1, 5'd5, '0, 5'd10, 1'b1, 1'b0, 1'b0);
        v[2] = 1'b1; rdv[2] = 5'd5; dv[2] = 32'h3F800000;
        drive();
        #1 chk("raw_stall", {63'd0, issue_stall}, 64'd1);
        chk("raw_gnt", {60'd0, req_ready}, 64'h4);
        cycle(1);
        v[2] = 1'b0;
        drive();
        #1 chk("raw_nostall", {63'd0, issue_stall}, 64'd0);
        chk("raw_we", {63'd0, wb_we}, 64'd1);
        chk("raw_rd", {59'd0, wb_rd}, 64'd5);
        chk("raw_bypass", {32'd0, wb_data}, 64'h3F800000);
        cycle(1);

        // WAW
        issue(1'b1, '0, '0, 5'd7, 1'b0, 1'b0, 1'b1);
        cycle(1);
        chk("waw_busy7", {63'd0, busy[7]}, 64'd1);
        #1 chk("waw_stall", {63'd0, issue_stall}, 64'd1);
        cycle(1);
        issue(1'b1, '0, '0, 5'd7, 1'b0, 1'b0, 1'b0);
        #1 chk("waw_nowr", {63'd0, issue_stall}, 64'd0);
        cycle(1);

        // simultaneous set/clear
        issue(1'b1, '0, '0, 5'd9, 1'b0, 1'b0, 1'b1);
        v[0] = 1'b1; rdv[0] = 5'd9; dv[0] = $urandom;
        drive();
        #1 chk("sim_gnt", {60'd0, req_ready}, 64'h1);
        cycle(1);
        chk("sim_busy9", {63'd0, busy[9]}, 64'd1);
        chk("sim_we", {63'd0, wb_we}, 64'd1);
        chk("sim_rd", {59'd0, wb_rd}, 64'd9);
        v[0] = 1'b0;
        issue(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive();

        // idle hold
        v[1] = 1'b1; rdv[1] = 5'd6; dv[1] = 32'h40490FDB;
        drive();
        cycle(1);
        v[1] = 1'b0;
        drive();
        for (int k = 0; k < 3; k++) begin
            cycle(1);
            chk("idle_we", {63'd0, wb_we}, 64'd0);
            chk("idle_rd", {59'd0, wb_rd}, 64'd6);
            chk("idle_data", {32'd0, wb_data}, 64'h40490FDB);
        end

        // randomized traffic
        prev_rst = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (prev_rst) begin
                for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
            end else if (last_g >= 0) begin
                v[last_g] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    v[i]   = 1'b1;
                    rdv[i] = AW'($urandom_range(0, 7));
                    dv[i]  = $urandom;
                end
            end
            rstn = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            drive();
            prev_rst = !rstn;
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
